// File: rtl/anim_sequencer_pkg.sv
// Shared definitions for the fighter animation path: state codes decoded by the
// sprite mapper and the anim_frame width.
package anim_defs;

   localparam int FRAME_W = 6;
   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 4'd0,
      ST_WALK = 4'd1,
      ST_JUMP = 4'd2,
      ST_ATK1 = 4'd3,
      ST_ATK2 = 4'd4,
      ST_HIT  = 4'd5,
      ST_LOSE = 4'd6
   } anim_state_e;

   function automatic logic is_busy(anim_state_e s);
      return (s == ST_JUMP) || (s == ST_ATK1) || (s == ST_ATK2) ||
             (s == ST_HIT)  || (s == ST_LOSE);
   endfunction

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/anim_sequencer_timer.sv
// Frame-tick down counter: load/clear, advances only on en, and flags expiry
// on the enabled tick that exhausts it, auto-reloading load_val for wrap use.
module anim_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   assign expire = en && (cnt_q == W'(1));

   // Reloading on expiry lets attack frames wrap without a load from the FSM.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (load || expire)
         cnt_d = load_val;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/anim_sequencer.sv
// Per-fighter animation sequencer: priority FSM over walk/jump/attack/hit/KO
// requests producing registered sprite state, frame index and status flags.
module anim_sequencer
   import anim_defs::*;
#(
   parameter int FRAME_TICKS   = 4,
   parameter int ATK1_FRAMES   = 4,
   parameter int ATK2_FRAMES   = 6,
   parameter int ATK1_ACTIVE   = 2,
   parameter int ATK2_ACTIVE   = 3,
   parameter int JUMP_TICKS    = 30,
   parameter int HITSTUN_TICKS = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       req_walk,
   input  logic       req_jump,
   input  logic       req_atk1,
   input  logic       req_atk2,
   input  logic       hit,
   input  logic       ko,
   output logic [3:0] anim_state,
   output logic [5:0] anim_frame,
   output logic       busy,
   output logic       hitbox_en,
   output logic       anim_done
);

   localparam int TMAX = max3(FRAME_TICKS, JUMP_TICKS, HITSTUN_TICKS);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [FRAME_W-1:0] ATK1_LAST = FRAME_W'(ATK1_FRAMES - 1);
   localparam logic [FRAME_W-1:0] ATK2_LAST = FRAME_W'(ATK2_FRAMES - 1);
   localparam logic [FRAME_W-1:0] ATK1_HB   = FRAME_W'(ATK1_ACTIVE);
   localparam logic [FRAME_W-1:0] ATK2_HB   = FRAME_W'(ATK2_ACTIVE);

   anim_state_e        state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               busy_q, busy_d;
   logic               hitbox_q, hitbox_d;
   logic               done_q, done_d;

   logic          tmr_clr, tmr_load, tmr_expire;
   logic [TW-1:0] tmr_val;

   anim_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (frame_tick),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      done_d   = 1'b0;
      tmr_clr  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;

      if (ko) begin
         state_d = ST_LOSE;
         frame_d = '0;
         tmr_clr = 1'b1;
      end else if (hit && (state_q != ST_LOSE)) begin
         // Entering HIT and re-stun share the same reload path.
         state_d  = ST_HIT;
         frame_d  = '0;
         tmr_load = 1'b1;
         tmr_val  = TW'(HITSTUN_TICKS);
      end else begin
         case (state_q)
            ST_IDLE, ST_WALK: begin
               frame_d  = '0;
               tmr_load = 1'b1;
               if (req_atk1) begin
                  state_d = ST_ATK1;
                  tmr_val = TW'(FRAME_TICKS);
               end else if (req_atk2) begin
                  state_d = ST_ATK2;
                  tmr_val = TW'(FRAME_TICKS);
               end else if (req_jump) begin
                  state_d = ST_JUMP;
                  tmr_val = TW'(JUMP_TICKS);
               end else begin
                  state_d  = req_walk ? ST_WALK : ST_IDLE;
                  tmr_load = 1'b0;
                  tmr_clr  = 1'b1;
               end
            end
            ST_ATK1, ST_ATK2: begin
               tmr_val = TW'(FRAME_TICKS);
               if (tmr_expire) begin
                  if (frame_q == ((state_q == ST_ATK1) ? ATK1_LAST : ATK2_LAST)) begin
                     state_d = req_walk ? ST_WALK : ST_IDLE;
                     frame_d = '0;
                     done_d  = 1'b1;
                     tmr_clr = 1'b1;
                  end else begin
                     frame_d = frame_q + FRAME_W'(1);
                  end
               end
            end
            ST_JUMP: begin
               tmr_val = TW'(JUMP_TICKS);
               if (tmr_expire) begin
                  state_d = req_walk ? ST_WALK : ST_IDLE;
                  done_d  = 1'b1;
                  tmr_clr = 1'b1;
               end
            end
            ST_HIT: begin
               tmr_val = TW'(HITSTUN_TICKS);
               if (tmr_expire) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  tmr_clr = 1'b1;
               end
            end
            ST_LOSE: begin
               frame_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
               frame_d = '0;
               tmr_clr = 1'b1;
            end
         endcase
      end

      busy_d   = is_busy(state_d);
      hitbox_d = ((state_d == ST_ATK1) && (frame_d == ATK1_HB)) ||
                 ((state_d == ST_ATK2) && (frame_d == ATK2_HB));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         frame_q  <= '0;
         busy_q   <= 1'b0;
         hitbox_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         busy_q   <= busy_d;
         hitbox_q <= hitbox_d;
         done_q   <= done_d;
      end
   end

   assign anim_state = state_q;
   assign anim_frame = frame_q;
   assign busy       = busy_q;
   assign hitbox_en  = hitbox_q;
   assign anim_done  = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with default parameters.
module tb_anim_sequencer;

   logic       clk = 1'b0;
   logic       rst, frame_tick, req_walk, req_jump, req_atk1, req_atk2, hit, ko;
   logic [3:0] anim_state;
   logic [5:0] anim_frame;
   logic       busy, hitbox_en, anim_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   anim_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .req_walk   (req_walk),
      .req_jump   (req_jump),
      .req_atk1   (req_atk1),
      .req_atk2   (req_atk2),
      .hit        (hit),
      .ko         (ko),
      .anim_state (anim_state),
      .anim_frame (anim_frame),
      .busy       (busy),
      .hitbox_en  (hitbox_en),
      .anim_done  (anim_done)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One frame_tick cycle; the next tick is left to the caller.
   task automatic tick_cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if ({anim_state, anim_frame, busy, hitbox_en, anim_done} !== 13'd0) begin
         failures++;
         $display("FAIL reset: got st=%0d fr=%0d busy=%b hb=%b done=%b, want all 0",
                  anim_state, anim_frame, busy, hitbox_en, anim_done);
      end
   endtask

   task automatic test_atk1();
      logic [3:0] es;
      logic [5:0] ef;
      logic       eh, ed;
      int         pulses;
      pulses = 0;
      req_atk1 = 1'b1;
      cyc();
      req_atk1 = 1'b0;
      checks++;
      if (anim_state !== 4'd3 || anim_frame !== 6'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL atk1_enter: got st=%0d fr=%0d busy=%b, want st=3 fr=0 busy=1",
                  anim_state, anim_frame, busy);
      end
      for (int t = 1; t <= 16; t++) begin
         tick_cyc();
         es = (t == 16) ? 4'd0 : 4'd3;
         ef = (t == 16) ? 6'd0 : 6'(t / 4);
         eh = (t < 16) && (t / 4 == 2);
         ed = (t == 16);
         if (anim_done === 1'b1) pulses++;
         checks++;
         if (anim_state !== es || anim_frame !== ef || hitbox_en !== eh || anim_done !== ed) begin
            failures++;
            $display("FAIL atk1_step t=%0d: got st=%0d fr=%0d hb=%b done=%b, want st=%0d fr=%0d hb=%b done=%b",
                     t, anim_state, anim_frame, hitbox_en, anim_done, es, ef, eh, ed);
         end
         cyc();
         if (anim_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || anim_state !== 4'd0) begin
         failures++;
         $display("FAIL atk1_done_count: got pulses=%0d st=%0d, want pulses=1 st=0", pulses, anim_state);
      end
   endtask

   task automatic test_jump_lockout();
      req_jump = 1'b1;
      cyc();
      req_jump = 1'b0;
      req_atk1 = 1'b1;
      checks++;
      if (anim_state !== 4'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL jump_enter: got st=%0d busy=%b, want st=2 busy=1", anim_state, busy);
      end
      for (int t = 1; t <= 30; t++) begin
         if (t == 30) req_atk1 = 1'b0;
         tick_cyc();
         checks++;
         if (anim_state !== ((t == 30) ? 4'd0 : 4'd2) || anim_done !== (t == 30)) begin
            failures++;
            $display("FAIL jump_hold t=%0d: got st=%0d done=%b, want st=%0d done=%b",
                     t, anim_state, anim_done, (t == 30) ? 0 : 2, (t == 30));
         end
         cyc();
      end
   endtask

   task automatic test_hit_restun();
      req_atk2 = 1'b1;
      cyc();
      req_atk2 = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick_cyc();
      end
      checks++;
      if (anim_state !== 4'd4 || anim_frame !== 6'd3 || hitbox_en !== 1'b1) begin
         failures++;
         $display("FAIL atk2_frame3: got st=%0d fr=%0d hb=%b, want st=4 fr=3 hb=1",
                  anim_state, anim_frame, hitbox_en);
      end
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      checks++;
      if (anim_state !== 4'd5 || anim_frame !== 6'd0 || hitbox_en !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL hit_enter: got st=%0d fr=%0d hb=%b busy=%b, want st=5 fr=0 hb=0 busy=1",
                  anim_state, anim_frame, hitbox_en, busy);
      end
      for (int t = 1; t <= 6; t++) tick_cyc();
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick_cyc();
         checks++;
         if (anim_state !== ((t == 12) ? 4'd0 : 4'd5) || anim_done !== (t == 12)) begin
            failures++;
            $display("FAIL restun t=%0d: got st=%0d done=%b, want st=%0d done=%b",
                     t, anim_state, anim_done, (t == 12) ? 0 : 5, (t == 12));
         end
      end
   endtask

   task automatic test_hit_on_last_tick();
      req_atk1 = 1'b1;
      cyc();
      req_atk1 = 1'b0;
      for (int t = 1; t <= 15; t++) tick_cyc();
      frame_tick = 1'b1;
      hit = 1'b1;
      cyc();
      frame_tick = 1'b0;
      hit = 1'b0;
      checks++;
      if (anim_state !== 4'd5 || anim_done !== 1'b0) begin
         failures++;
         $display("FAIL hit_last_tick: got st=%0d done=%b, want st=5 done=0", anim_state, anim_done);
      end
      for (int t = 1; t <= 12; t++) tick_cyc();
      checks++;
      if (anim_state !== 4'd0 || anim_done !== 1'b1) begin
         failures++;
         $display("FAIL hit_recover: got st=%0d done=%b, want st=0 done=1", anim_state, anim_done);
      end
      cyc();
   endtask

   task automatic test_ko();
      ko = 1'b1;
      hit = 1'b1;
      cyc();
      ko = 1'b0;
      hit = 1'b0;
      checks++;
      if (anim_state !== 4'd6 || anim_frame !== 6'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL ko_enter: got st=%0d fr=%0d busy=%b, want st=6 fr=0 busy=1",
                  anim_state, anim_frame, busy);
      end
      req_atk1 = 1'b1;
      req_walk = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         hit = (t == 2);
         tick_cyc();
      end
      hit = 1'b0;
      req_atk1 = 1'b0;
      req_walk = 1'b0;
      checks++;
      if (anim_state !== 4'd6 || anim_done !== 1'b0) begin
         failures++;
         $display("FAIL ko_hold: got st=%0d done=%b, want st=6 done=0", anim_state, anim_done);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (anim_state !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ko_reset: got st=%0d busy=%b, want st=0 busy=0", anim_state, busy);
      end
   endtask

   task automatic test_priority();
      req_atk1 = 1'b1;
      req_atk2 = 1'b1;
      req_walk = 1'b1;
      cyc();
      req_atk1 = 1'b0;
      req_atk2 = 1'b0;
      checks++;
      if (anim_state !== 4'd3) begin
         failures++;
         $display("FAIL priority: got st=%0d, want st=3", anim_state);
      end
      for (int t = 1; t <= 16; t++) tick_cyc();
      checks++;
      if (anim_state !== 4'd1 || anim_done !== 1'b1) begin
         failures++;
         $display("FAIL atk_to_walk: got st=%0d done=%b, want st=1 done=1", anim_state, anim_done);
      end
      req_walk = 1'b0;
      cyc();
      checks++;
      if (anim_state !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL walk_release: got st=%0d busy=%b, want st=0 busy=0", anim_state, busy);
      end
   endtask

   task automatic test_rst_mid_attack();
      req_atk1 = 1'b1;
      cyc();
      req_atk1 = 1'b0;
      for (int t = 1; t <= 8; t++) tick_cyc();
      checks++;
      if (anim_state !== 4'd3 || anim_frame !== 6'd2 || hitbox_en !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst: got st=%0d fr=%0d hb=%b, want st=3 fr=2 hb=1",
                  anim_state, anim_frame, hitbox_en);
      end
      rst = 1'b1;
      req_atk1 = 1'b1;
      hit = 1'b1;
      frame_tick = 1'b1;
      cyc();
      rst = 1'b0;
      req_atk1 = 1'b0;
      hit = 1'b0;
      frame_tick = 1'b0;
      checks++;
      if ({anim_state, anim_frame, busy, hitbox_en, anim_done} !== 13'd0) begin
         failures++;
         $display("FAIL rst_mid: got st=%0d fr=%0d busy=%b hb=%b done=%b, want all 0",
                  anim_state, anim_frame, busy, hitbox_en, anim_done);
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_tick = 1'b0;
      req_walk = 1'b0;
      req_jump = 1'b0;
      req_atk1 = 1'b0;
      req_atk2 = 1'b0;
      hit = 1'b0;
      ko = 1'b0;
      test_reset();
      test_atk1();
      test_jump_lockout();
      test_hit_restun();
      test_hit_on_last_tick();
      test_ko();
      test_priority();
      test_rst_mid_attack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Per-fighter animation controller. It turns player/game-logic requests (walk, jump, two attacks, hit, KO) into the registered `anim_state`/`anim_frame` pair that drives the sprite ID lookup. It enforces action priority, move lockout, attack frame stepping, jump airtime and hitstun duration, all timed in units of the video frame tick. One instance sits per fighter, between the input/collision logic and the sprite mapper.

## Interface
- `FRAME_TICKS`, 4: frame_ticks per attack animation frame (≥1)
- `ATK1_FRAMES`, 4: frames in attack 1 (1..63)
- `ATK2_FRAMES`, 6: frames in attack 2 (1..63)
- `ATK1_ACTIVE`, 2: attack-1 frame index with hitbox enabled
- `ATK2_ACTIVE`, 3: attack-2 frame index with hitbox enabled
- `JUMP_TICKS`, 30: jump airtime in frame_ticks (≥1)
- `HITSTUN_TICKS`, 12: hitstun duration in frame_ticks (≥1)

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per video frame (vsync)
- `req_walk` in 1: level, horizontal move held
- `req_jump` in 1: level, jump pressed
- `req_atk1` in 1: level, attack 1 pressed
- `req_atk2` in 1: level, attack 2 pressed
- `hit` in 1: one-cycle pulse, fighter was struck
- `ko` in 1: level or pulse, health reached zero
- `anim_state` out 4: 0 idle, 1 walk, 2 jump, 3 atk1, 4 atk2, 5 hit, 6 lose
- `anim_frame` out 6: frame index within attack; 0 in all other states
- `busy` out 1: high in jump/atk1/atk2/hit/lose (requests locked out)
- `hitbox_en` out 1: high while attack is on its active frame
- `anim_done` out 1: one-cycle pulse when atk1/atk2/jump/hit completes

## Operation
- Reset: `anim_state`=0, `anim_frame`=0, tick counter=0, `busy`=0, `hitbox_en`=0, `anim_done`=0.
- Priority, evaluated every clk: ko > hit > (current busy action continues) > atk1 > atk2 > jump > walk > idle.
- LOSE: entered on `ko` from any state; terminal until `rst`; `anim_frame`=0.
- HIT: entered on `hit` from any state except LOSE. Aborts attack/jump, clears `anim_frame` and tick counter, and loads the stun counter with HITSTUN_TICKS. A `hit` while already in HIT reloads the counter (re-stun). When the counter expires the state goes to IDLE and `anim_done` pulses.
- IDLE/WALK (not busy): `req_atk1` → ATK1; otherwise `req_atk2` → ATK2; otherwise `req_jump` → JUMP; otherwise WALK if `req_walk`, else IDLE. Entering any action clears `anim_frame` and the tick counter.
- ATK1/ATK2: on each `frame_tick` the tick counter increments. At FRAME_TICKS-1 the counter wraps to 0 and `anim_frame` increments. If `anim_frame` is already N-1, the state returns to WALK/IDLE per `req_walk` and `anim_done` pulses. Total attack duration is N×FRAME_TICKS frame_ticks. Attack requests are ignored while busy; there is no buffering.
- JUMP: counts JUMP_TICKS frame_ticks, then returns to WALK/IDLE and pulses `anim_done`. Attacks are not permitted airborne.
- `hitbox_en` = (state==ATK1 && `anim_frame`==ATK1_ACTIVE) || (state==ATK2 && `anim_frame`==ATK2_ACTIVE).
- Widths: tick counter is sized for max(FRAME_TICKS, JUMP_TICKS, HITSTUN_TICKS). `anim_frame` never exceeds N-1.

## Timing
- All outputs are registered. A state change is visible the cycle after the causing input is sampled.
- Counters advance only on cycles with `frame_tick`=1. Requests are sampled every clk.
- When `hit` coincides with the final attack `frame_tick`, the state goes to HIT and `anim_done` stays 0.
- When `ko` coincides with `hit`, the state goes to LOSE.
- `rst` mid-action forces reset values on the next edge, regardless of other inputs.
- `anim_done` and `hitbox_en` derive from the registered state, so there are no combinational input→output paths.

## Structure
- Shared package `anim_defs`: state codes 0–6 (the same codes the sprite mapper decodes) and the `anim_frame` width of 6.
- Sub-module `anim_timer`: tick counter with load value, `frame_tick` enable, wrap/expire pulse and clear. The sequencer instantiates it once and loads it per state.
- The top level holds the priority FSM and the `anim_frame` register.

## Test plan
- Reset, then `req_atk1` for 1 clk → `anim_state`=3. `anim_frame` steps 0,1,2,3 every 4 frame_ticks. `hitbox_en` is high only while frame==2. After 16 ticks `anim_state`=0 with one `anim_done` pulse.
- `req_jump` held, then `req_atk1` asserted during JUMP → `anim_state` stays 2 for 30 ticks, then returns to 0. The attack is ignored.
- `hit` pulse while ATK2 is on frame 3 → `anim_state`=5 and `anim_frame`=0 next clk. A second `hit` after 6 ticks extends stun to 18 ticks total, then IDLE.
- `ko` and `hit` in the same cycle → `anim_state`=6. It holds through further inputs until `rst`, then 0.
- `req_atk1`, `req_atk2` and `req_walk` all high from IDLE → ATK1. After completion with `req_walk` still high → `anim_state`=1.
- `rst` asserted mid-ATK1 on frame 2 → next clk all outputs are at their reset values.
